// File: rtl/mdu_pkg.sv
// mdu_pkg: shared op codes, FSM state encoding and default latencies for the
// multiply/divide unit. Build option: MDU_MADD_EN makes MD_MADD/MD_MADDU legal
// multi-cycle ops; without it those codes are treated as no-ops.
package mdu_pkg;

    typedef logic [3:0] md_op_t;

    localparam md_op_t MD_NONE  = 4'd0;
    localparam md_op_t MD_MULT  = 4'd1;
    localparam md_op_t MD_MULTU = 4'd2;
    localparam md_op_t MD_DIV   = 4'd3;
    localparam md_op_t MD_DIVU  = 4'd4;
    localparam md_op_t MD_MTHI  = 4'd5;
    localparam md_op_t MD_MTLO  = 4'd6;
    localparam md_op_t MD_MADD  = 4'd7;
    localparam md_op_t MD_MADDU = 4'd8;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    // Ops that occupy the unit for a busy period (mult/div class).
    function automatic logic is_long_op(input md_op_t op);
        logic r;
        case (op)
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: r = 1'b1;
`ifdef MDU_MADD_EN
            MD_MADD, MD_MADDU:                  r = 1'b1;
`endif
            default:                            r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic is_div_op(input md_op_t op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// mdu_arith: combinational 64-bit {HI,LO} result for the latched op/operands.
// Multiply-accumulate codes are always decoded here; whether they can ever be
// latched is decided by the controller (MDU_MADD_EN).
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [3:0]  i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic [31:0] i_hi,
    input  logic [31:0] i_lo,
    output logic [63:0] o_result,
    output logic        o_div_zero
);

    logic signed [63:0] w_sprod;
    logic        [63:0] w_uprod;
    logic        [31:0] w_b_safe;
    logic signed [31:0] w_squot;
    logic signed [31:0] w_srem;
    logic        [31:0] w_uquot;
    logic        [31:0] w_urem;

    assign w_sprod  = $signed({{32{i_a[31]}}, i_a}) * $signed({{32{i_b[31]}}, i_b});
    assign w_uprod  = {32'b0, i_a} * {32'b0, i_b};
    // A zero divisor never reaches HI/LO; substitute 1 to keep the divider defined.
    assign w_b_safe = (i_b == 32'd0) ? 32'd1 : i_b;
    assign w_squot  = $signed(i_a) / $signed(w_b_safe);
    assign w_srem   = $signed(i_a) % $signed(w_b_safe);
    assign w_uquot  = i_a / w_b_safe;
    assign w_urem   = i_a % w_b_safe;

    assign o_div_zero = is_div_op(i_op) && (i_b == 32'd0);

    // Select the result for the latched operation; divide packs {rem, quot}.
    always_comb begin
        o_result = 64'd0;
        case (i_op)
            MD_MULT:  o_result = w_sprod;
            MD_MULTU: o_result = w_uprod;
            MD_DIV:   o_result = {w_srem, w_squot};
            MD_DIVU:  o_result = {w_urem, w_uquot};
            MD_MADD:  o_result = {i_hi, i_lo} + w_sprod;
            MD_MADDU: o_result = {i_hi, i_lo} + w_uprod;
            default:  o_result = 64'd0;
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: MDU controller - accepts E-stage ops, runs a fixed-latency
// down-counter, owns HI/LO and requests F/D stalls.
// Build option: MDU_MADD_EN enables MD_MADD/MD_MADDU (decoded in mdu_pkg).
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | ready; mthi/mtlo write immediately, mult/div class loads counter
//   RUN   | counting down; HI/LO written on the edge where counter == 1
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        d_md_use,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    logic [0:0]  r_state;
    logic [3:0]  r_cnt;
    logic [3:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_start_acc;
    logic [63:0] w_result;
    logic        w_div_zero;

    mdu_arith u_arith (
        .i_op       (r_op),
        .i_a        (r_a),
        .i_b        (r_b),
        .i_hi       (r_hi),
        .i_lo       (r_lo),
        .o_result   (w_result),
        .o_div_zero (w_div_zero)
    );

    assign busy        = (r_state == ST_RUN);
    assign w_start_acc = start & ~busy & is_long_op(md_op);
    assign stall       = d_md_use & (busy | w_start_acc);
    assign hi          = r_hi;
    assign lo          = r_lo;

    // FSM, latency counter, operand latches and HI/LO updates.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_op    <= MD_NONE;
            r_a     <= 32'd0;
            r_b     <= 32'd0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start_acc) begin
                        r_op    <= md_op;
                        r_a     <= rs_val;
                        r_b     <= rt_val;
                        r_cnt   <= is_div_op(md_op) ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
                        r_state <= ST_RUN;
                    end else if (start && md_op == MD_MTHI) begin
                        r_hi <= rs_val;
                    end else if (start && md_op == MD_MTLO) begin
                        r_lo <= rs_val;
                    end
                end
                default: begin
                    if (r_cnt == 4'd1) begin
                        r_cnt   <= 4'd0;
                        r_state <= ST_IDLE;
                        if (!w_div_zero) begin
                            r_hi <= w_result[63:32];
                            r_lo <= w_result[31:0];
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: behavioural HI/LO model checked every
// cycle, plus literal expectations from hand-computed vectors.
module tb_mdu_ctrl;

    localparam int MC = 5;
    localparam int DC = 10;

    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  md_op = 4'd0;
    logic [31:0] rs_val = 32'd0;
    logic [31:0] rt_val = 32'd0;
    logic        d_md_use = 1'b0;
    logic        busy, stall;
    logic [31:0] hi, lo;

    int n_checks = 0;
    int n_fail   = 0;

    mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .md_op    (md_op),
        .rs_val   (rs_val),
        .rt_val   (rt_val),
        .d_md_use (d_md_use),
        .busy     (busy),
        .stall    (stall),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic        model_ok = 1'b0;
    logic        m_busy = 1'b0;
    longint      m_cyc = 0;
    longint      m_done = 0;
    logic [3:0]  m_op;
    logic [31:0] m_a, m_b;
    logic [31:0] m_hi = 32'd0, m_lo = 32'd0;

    function automatic logic tb_long(input logic [3:0] op);
        if (op >= OP_MULT && op <= OP_DIVU) return 1'b1;
`ifdef MDU_MADD_EN
        if (op == OP_MADD || op == OP_MADDU) return 1'b1;
`endif
        return 1'b0;
    endfunction

    // Signed 32-bit value as a 64-bit integer.
    function automatic longint sx(input logic [31:0] v);
        return v[31] ? longint'({32'hFFFF_FFFF, v}) : longint'({32'd0, v});
    endfunction

    // Complete an op: update m_hi/m_lo from the specification's arithmetic rules.
    task automatic model_finish();
        logic [63:0] r;
        longint a, b, q, mag_q;
        case (m_op)
            OP_MULT:  r = 64'(sx(m_a) * sx(m_b));
            OP_MULTU: r = {32'd0, m_a} * {32'd0, m_b};
            OP_MADD:  r = {m_hi, m_lo} + 64'(sx(m_a) * sx(m_b));
            OP_MADDU: r = {m_hi, m_lo} + {32'd0, m_a} * {32'd0, m_b};
            OP_DIV, OP_DIVU: begin
                if (m_b == 32'd0) return;
                a = (m_op == OP_DIV) ? sx(m_a) : longint'({32'd0, m_a});
                b = (m_op == OP_DIV) ? sx(m_b) : longint'({32'd0, m_b});
                mag_q = (a < 0 ? -a : a) / (b < 0 ? -b : b);
                q = ((a < 0) != (b < 0)) ? -mag_q : mag_q;
                r = {32'(a - q * b), 32'(q)};
            end
            default:  return;
        endcase
        m_hi = r[63:32];
        m_lo = r[31:0];
    endtask

    always @(posedge clk) begin
        if (reset) begin
            model_ok = 1'b1;
            m_busy = 1'b0;
            m_hi = 32'd0;
            m_lo = 32'd0;
        end else if (m_busy) begin
            if (m_cyc == m_done) begin
                model_finish();
                m_busy = 1'b0;
            end
        end else if (start) begin
            if (tb_long(md_op)) begin
                m_busy = 1'b1;
                m_op = md_op;
                m_a = rs_val;
                m_b = rt_val;
                m_done = m_cyc + ((md_op == OP_DIV || md_op == OP_DIVU) ? DC : MC);
            end else if (md_op == OP_MTHI) m_hi = rs_val;
            else if (md_op == OP_MTLO) m_lo = rs_val;
        end
        m_cyc++;
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        logic exp_stall;
        if (!model_ok) return;
        exp_stall = d_md_use & (m_busy | (start & ~m_busy & tb_long(md_op)));
        chk("busy", {31'd0, busy}, {31'd0, m_busy});
        chk("stall", {31'd0, stall}, {31'd0, exp_stall});
        chk("hi", hi, m_hi);
        chk("lo", lo, m_lo);
    endtask

    // One clock: compare at the falling edge, return just after the rising edge.
    task automatic cycle();
        @(negedge clk);
        compare_model();
        @(posedge clk);
        #1;
    endtask

    // Issue an op for exactly one edge, then scramble operands.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; md_op = op; rs_val = a; rt_val = b;
        cycle();
        start = 1'b0; md_op = OP_NONE; rs_val = 32'hDEAD_BEEF; rt_val = 32'h0BAD_F00D;
    endtask

    // Count cycles with busy high; bounded.
    task automatic busy_len(input string name, input int exp);
        int n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            cycle();
        end
        chk(name, 32'(n), 32'(exp));
    endtask

    initial begin
        reset = 1'b1;
        cycle();
        cycle();
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);
        reset = 1'b0;
        cycle();

        // mult -3 * 4
        issue(OP_MULT, 32'hFFFF_FFFD, 32'd4);
        busy_len("mult_busy_len", 5);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFF4);

        // multu 0xFFFFFFFF * 2
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'd2);
        busy_len("multu_busy_len", 5);
        chk("multu_hi", hi, 32'h0000_0001);
        chk("multu_lo", lo, 32'hFFFF_FFFE);

        // div -7 / 2
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        busy_len("div_busy_len", 10);
        chk("div_lo", lo, 32'hFFFF_FFFD);
        chk("div_hi", hi, 32'hFFFF_FFFF);

        // divu 100 / 7 -> q=14 r=2
        issue(OP_DIVU, 32'd100, 32'd7);
        busy_len("divu_busy_len", 10);
        chk("divu_lo", lo, 32'd14);
        chk("divu_hi", hi, 32'd2);

        // mthi with D-stage MDU use: no stall for a non-busy op
        d_md_use = 1'b1;
        start = 1'b1; md_op = OP_MTHI; rs_val = 32'h1234_5678;
        #1;
        chk("mthi_no_stall", {31'd0, stall}, 32'd0);
        cycle();
        start = 1'b0; md_op = OP_NONE; d_md_use = 1'b0;
        chk("mthi_hi", hi, 32'h1234_5678);
        chk("mthi_busy", {31'd0, busy}, 32'd0);

        // divide by zero keeps HI/LO, full latency
        issue(OP_DIVU, 32'd5, 32'd0);
        busy_len("div0_busy_len", 10);
        chk("div0_hi", hi, 32'h1234_5678);
        chk("div0_lo", lo, 32'd14);

        // mtlo then signed divide 7 / -2 -> q=-3 r=1
        issue(OP_MTLO, 32'hCAFE_0001, 32'd0);
        chk("mtlo_lo", lo, 32'hCAFE_0001);
        issue(OP_DIV, 32'd7, 32'hFFFF_FFFE);
        busy_len("div2_busy_len", 10);
        chk("div2_lo", lo, 32'hFFFF_FFFD);
        chk("div2_hi", hi, 32'd1);

        // stall in the issue cycle when D holds an MDU op
        d_md_use = 1'b1;
        start = 1'b1; md_op = OP_MULT; rs_val = 32'd3; rt_val = 32'd3;
        #1;
        chk("issue_stall", {31'd0, stall}, 32'd1);
        cycle();
        start = 1'b0; md_op = OP_NONE; d_md_use = 1'b0;
        busy_len("mult9_busy_len", 5);
        chk("mult9_lo", lo, 32'd9);

        // div aborted by reset at k+3; a start while busy is ignored
        issue(OP_DIV, 32'd1000, 32'd3);
        start = 1'b1; md_op = OP_MULT; rs_val = 32'd2; rt_val = 32'd2; d_md_use = 1'b1;
        #1;
        chk("busy_stall", {31'd0, stall}, 32'd1);
        cycle();
        start = 1'b0; md_op = OP_NONE; d_md_use = 1'b0;
        cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_hi", hi, 32'd0);
        chk("abort_lo", lo, 32'd0);
        repeat (12) cycle();
        chk("abort_late_hi", hi, 32'd0);
        chk("abort_late_lo", lo, 32'd0);

        // undefined op code is a no-op
        issue(4'd15, 32'h5555_5555, 32'd1);
        chk("undef_busy", {31'd0, busy}, 32'd0);
        chk("undef_hi", hi, 32'd0);

        // maddu accumulate
        issue(OP_MTLO, 32'hFFFF_FFFF, 32'd0);
        issue(OP_MADDU, 32'd1, 32'd1);
`ifdef MDU_MADD_EN
        busy_len("maddu_busy_len", 5);
        chk("maddu_hi", hi, 32'd1);
        chk("maddu_lo", lo, 32'd0);
`else
        chk("maddu_busy", {31'd0, busy}, 32'd0);
        repeat (6) cycle();
        chk("maddu_hi", hi, 32'd0);
        chk("maddu_lo", lo, 32'hFFFF_FFFF);
`endif
        repeat (3) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
